if_stage_pipe: RTL and testbench

- Parametrised instruction-fetch stage that drives the instruction-memory address from an internal PC and captures {pc, instr} into the IF/ID pipeline register.
- Extends the basic fetch-and-increment stage with:
  - asynchronous reset to a programmable vector
  - ID-stage stall
  - redirect with wrong-path flush
  - instruction-memory wait states
  - a valid bit and bubble insertion
  - misaligned-target detection and a fetched-instruction counter
- Sits between the instruction memory and the decode stage.

---
 rtl/if_stage_pipe.sv | 73 +++++++
 tb/tb_if_stage_pipe.sv | 186 ++++++++++++++++++
 2 files changed

// File: rtl/if_stage_pipe.sv
// Instruction-fetch stage: drives the instruction-memory address from the
// internal PC and registers {pc, instr} into the IF/ID pipeline register.
// Each edge applies exactly one action, in priority order: redirect
// (flush the wrong path), stall (hold everything), memory wait (insert a
// bubble), fetch (capture the word and advance the PC).
module if_stage_pipe #(
  parameter int              XLEN        = 32,
  parameter int              INSTR_BYTES = 4,
  parameter logic [XLEN-1:0] RESET_PC    = '0,
  parameter logic [XLEN-1:0] NOP_INSTR   = 'h00000013,
  parameter int              CNT_W       = 16
) (
  input  logic              clk,
  input  logic              rst,
  input  logic              stall,
  input  logic              redirect_valid,
  input  logic [XLEN-1:0]   redirect_pc,
  output logic [XLEN-1:0]   imem_addr,
  input  logic [XLEN-1:0]   imem_rdata,
  input  logic              imem_ready,
  output logic [2*XLEN-1:0] if_id_bus,
  output logic              if_id_valid,
  output logic [CNT_W-1:0]  fetch_count,
  output logic              misalign
);

  localparam logic [XLEN-1:0] PC_INC     = XLEN'(INSTR_BYTES);
  // INSTR_BYTES is a power of two, so alignment is a test of the low bits.
  localparam logic [XLEN-1:0] ALIGN_MASK = XLEN'(INSTR_BYTES - 1);

  logic [XLEN-1:0] pc;
  logic [XLEN-1:0] bus_pc;
  logic [XLEN-1:0] bus_instr;

  // The memory address is the PC itself, with no register stage.
  assign imem_addr = pc;
  assign if_id_bus = {bus_pc, bus_instr};

  // PC, IF/ID register, valid bit, counter and misalign flag, updated
  // according to the per-edge priority: redirect > stall > wait > fetch.
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      pc          <= RESET_PC;
      bus_pc      <= '0;
      bus_instr   <= NOP_INSTR;
      if_id_valid <= 1'b0;
      fetch_count <= '0;
      misalign    <= 1'b0;
    end else if (redirect_valid) begin
      // Wrong-path flush; a misaligned target is still loaded unmodified
      // and the trap is raised downstream.
      pc          <= redirect_pc;
      bus_pc      <= '0;
      bus_instr   <= NOP_INSTR;
      if_id_valid <= 1'b0;
      misalign    <= |(redirect_pc & ALIGN_MASK);
    end else if (stall) begin
      // Hold everything; the memory word is ignored this cycle.
    end else if (!imem_ready) begin
      // Memory wait state: the PC holds and a bubble enters IF/ID.
      bus_pc      <= '0;
      bus_instr   <= NOP_INSTR;
      if_id_valid <= 1'b0;
    end else begin
      bus_pc      <= pc;
      bus_instr   <= imem_rdata;
      if_id_valid <= 1'b1;
      pc          <= pc + PC_INC;
      fetch_count <= fetch_count + 1'b1;
    end
  end

endmodule

// File: tb/tb_if_stage_pipe.sv
// Bench for if_stage_pipe: a directed vector table, randomized traffic
// against a behavioural model, an asynchronous mid-stream reset, and a
// second instance with a reset vector near the top of the address space
// that exercises PC wrap-around.
module tb_if_stage_pipe;

  localparam logic [31:0] NOP = 32'h00000013;

  logic        clk = 1'b0;
  logic        rst, stall, redirect_valid, imem_ready;
  logic [31:0] redirect_pc, imem_addr, imem_rdata;
  logic [63:0] if_id_bus;
  logic        if_id_valid, misalign;
  logic [15:0] fetch_count;

  logic        w_rst;
  logic [31:0] w_addr;
  logic [63:0] w_bus;
  logic        w_valid, w_mis;
  logic [15:0] w_cnt;

  int errors = 0;
  int checks = 0;

  // Behavioural model of the architectural state.
  logic [31:0] m_pc, m_bpc, m_ins;
  logic        m_v, m_mis;
  int          m_cnt;

  always #5 clk = ~clk;

  if_stage_pipe dut (
    .clk(clk), .rst(rst), .stall(stall), .redirect_valid(redirect_valid),
    .redirect_pc(redirect_pc), .imem_addr(imem_addr), .imem_rdata(imem_rdata),
    .imem_ready(imem_ready), .if_id_bus(if_id_bus), .if_id_valid(if_id_valid),
    .fetch_count(fetch_count), .misalign(misalign)
  );

  if_stage_pipe #(.RESET_PC(32'hFFFFFFF8)) u_wrap (
    .clk(clk), .rst(w_rst), .stall(1'b0), .redirect_valid(1'b0),
    .redirect_pc(32'h0), .imem_addr(w_addr), .imem_rdata(32'h00001234),
    .imem_ready(1'b1), .if_id_bus(w_bus), .if_id_valid(w_valid),
    .fetch_count(w_cnt), .misalign(w_mis)
  );

  task automatic chk(input string name, input logic [63:0] act, input logic [63:0] exp);
    checks++;
    if (act !== exp) begin
      errors++;
      $display("FAIL %s: got %h expected %h", name, act, exp);
    end
  endtask

  function automatic logic [31:0] mem(input logic [31:0] a);
    return a + 32'hA0;
  endfunction

  task automatic model_reset();
    m_pc = 32'h0; m_bpc = 32'h0; m_ins = NOP; m_v = 1'b0; m_mis = 1'b0; m_cnt = 0;
  endtask

  task automatic cmp_model(input string tag);
    chk({tag, ".bus"},   if_id_bus,   {m_bpc, m_ins});
    chk({tag, ".valid"}, if_id_valid, m_v);
    chk({tag, ".cnt"},   fetch_count, 64'(m_cnt % 65536));
    chk({tag, ".mis"},   misalign,    m_mis);
    chk({tag, ".addr"},  imem_addr,   m_pc);
  endtask

  // Drive one cycle of inputs, advance the model by the rules, clock, compare.
  task automatic step(input logic st, input logic rv, input logic [31:0] rpc,
                      input logic rdy, input logic [31:0] rd, input string tag);
    stall = st; redirect_valid = rv; redirect_pc = rpc; imem_ready = rdy; imem_rdata = rd;
    #1 chk({tag, ".addr_pre"}, imem_addr, m_pc);
    if (rv) begin
      m_pc = rpc; m_bpc = 32'h0; m_ins = NOP; m_v = 1'b0; m_mis = (rpc % 4) != 0;
    end else if (st) begin
      // nothing changes
    end else if (!rdy) begin
      m_bpc = 32'h0; m_ins = NOP; m_v = 1'b0;
    end else begin
      m_bpc = m_pc; m_ins = rd; m_v = 1'b1;
      m_pc = 32'((64'(m_pc) + 4) % 64'h1_0000_0000);
      m_cnt = m_cnt + 1;
    end
    @(posedge clk); #1;
    cmp_model(tag);
  endtask

  typedef struct {
    logic        st, rv, rdy;
    logic [31:0] rpc;
    logic [31:0] e_bpc, e_ins;
    logic        e_v;
    int          e_cnt;
    logic        e_mis;
    logic [31:0] e_addr;
  } vec_t;

  vec_t vt[19];

  initial begin
    // st rv rdy rpc | bus pc, instr, valid, cnt, mis, next addr
    vt[0]  = '{0,0,1,32'h0,        32'h0,        32'hA0,  1,1,0,32'h4};
    vt[1]  = '{0,0,1,32'h0,        32'h4,        32'hA4,  1,2,0,32'h8};
    vt[2]  = '{1,0,1,32'h0,        32'h4,        32'hA4,  1,2,0,32'h8};
    vt[3]  = '{1,0,1,32'h0,        32'h4,        32'hA4,  1,2,0,32'h8};
    vt[4]  = '{1,0,1,32'h0,        32'h4,        32'hA4,  1,2,0,32'h8};
    vt[5]  = '{0,0,1,32'h0,        32'h8,        32'hA8,  1,3,0,32'hC};
    vt[6]  = '{0,0,0,32'h0,        32'h0,        NOP,     0,3,0,32'hC};
    vt[7]  = '{0,0,0,32'h0,        32'h0,        NOP,     0,3,0,32'hC};
    vt[8]  = '{0,0,1,32'h0,        32'hC,        32'hAC,  1,4,0,32'h10};
    vt[9]  = '{1,1,1,32'h100,      32'h0,        NOP,     0,4,0,32'h100};
    vt[10] = '{0,0,1,32'h0,        32'h100,      32'h1A0, 1,5,0,32'h104};
    vt[11] = '{0,1,0,32'h102,      32'h0,        NOP,     0,5,1,32'h102};
    vt[12] = '{0,0,1,32'h0,        32'h102,      32'h1A2, 1,6,1,32'h106};
    vt[13] = '{1,0,1,32'h0,        32'h102,      32'h1A2, 1,6,1,32'h106};
    vt[14] = '{0,1,1,32'h200,      32'h0,        NOP,     0,6,0,32'h200};
    vt[15] = '{0,1,1,32'hFFFFFFF8, 32'h0,        NOP,     0,6,0,32'hFFFFFFF8};
    vt[16] = '{0,0,1,32'h0,        32'hFFFFFFF8, 32'h98,  1,7,0,32'hFFFFFFFC};
    vt[17] = '{0,0,1,32'h0,        32'hFFFFFFFC, 32'h9C,  1,8,0,32'h0};
    vt[18] = '{0,0,1,32'h0,        32'h0,        32'hA0,  1,9,0,32'h4};

    rst = 1'b1; w_rst = 1'b1;
    stall = 1'b0; redirect_valid = 1'b0; redirect_pc = 32'h0;
    imem_ready = 1'b1; imem_rdata = 32'h0;
    model_reset();
    #2;
    cmp_model("reset");
    chk("wrap.reset_addr", w_addr, 32'hFFFFFFF8);
    chk("wrap.reset_bus",  w_bus,  {32'h0, NOP});
    @(posedge clk); #1;
    rst = 1'b0;

    // Directed table; memory returns 0xA0 + address.
    for (int i = 0; i < 19; i++) begin
      string t;
      t = $sformatf("vec%0d", i);
      step(vt[i].st, vt[i].rv, vt[i].rpc, vt[i].rdy, mem(m_pc), t);
      chk({t, ".tbus"},  if_id_bus,   {vt[i].e_bpc, vt[i].e_ins});
      chk({t, ".tval"},  if_id_valid, vt[i].e_v);
      chk({t, ".tcnt"},  fetch_count, 64'(vt[i].e_cnt));
      chk({t, ".tmis"},  misalign,    vt[i].e_mis);
      chk({t, ".taddr"}, imem_addr,   vt[i].e_addr);
    end

    // Randomized traffic against the model.
    for (int i = 0; i < 300; i++) begin
      logic        st, rv, rdy;
      logic [31:0] rpc;
      st  = ($urandom_range(0, 3) == 0);
      rv  = ($urandom_range(0, 7) == 0);
      rdy = ($urandom_range(0, 3) != 0);
      rpc = $urandom;
      if ($urandom_range(0, 1) == 1) rpc[1:0] = 2'b00;
      step(st, rv, rpc, rdy, $urandom, "rand");
    end

    // Asynchronous reset between edges, during a stall with a redirect pending.
    stall = 1'b1; redirect_valid = 1'b1; redirect_pc = 32'h00000333;
    #2 rst = 1'b1;
    #1;
    model_reset();
    cmp_model("async_rst");
    #1 rst = 1'b0;
    step(0, 0, 32'h0, 1, mem(m_pc), "post_rst");
    chk("post_rst.pc0", if_id_bus[63:32], 32'h0);

    // Reset vector near the top of the space: the PC wraps to zero.
    #3 w_rst = 1'b0;
    @(posedge clk); #1;
    chk("wrap.bus0",  w_bus,  {32'hFFFFFFF8, 32'h00001234});
    chk("wrap.addr0", w_addr, 32'hFFFFFFFC);
    @(posedge clk); #1;
    chk("wrap.bus1",  w_bus,  {32'hFFFFFFFC, 32'h00001234});
    chk("wrap.addr1", w_addr, 32'h0);
    @(posedge clk); #1;
    chk("wrap.bus2",  w_bus,  {32'h0, 32'h00001234});
    chk("wrap.cnt",   w_cnt,  16'd3);
    chk("wrap.valid", w_valid, 1'b1);

    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end

endmodule
